// File: rtl/sll_iter.sv
// ============================================================================
// Module   : sll_iter
// Brief    : Iterative 32-bit shift-left-logical, one binary-weighted stage/clk
// Revision : 1.0
// ============================================================================
`default_nettype none

module sll_iter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_w, w_w_nxt, w_stage;
  logic [4:0]  r_s, w_s_nxt;
  logic [2:0]  r_k, w_k_nxt;
  logic [31:0] w_out_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  // Stage k applies the 2^(4-k) shift when the matching amount bit is set
  always_comb begin
    w_stage = r_w;
    case (r_k)
      3'd0:    if (r_s[4]) w_stage = {r_w[15:0], 16'h0000};
      3'd1:    if (r_s[3]) w_stage = {r_w[23:0], 8'h00};
      3'd2:    if (r_s[2]) w_stage = {r_w[27:0], 4'h0};
      3'd3:    if (r_s[1]) w_stage = {r_w[29:0], 2'b00};
      3'd4:    if (r_s[0]) w_stage = {r_w[30:0], 1'b0};
      default: w_stage = r_w;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_s_nxt     = r_s;
    w_k_nxt     = r_k;
    w_out_nxt   = out;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_w_nxt     = in;
          w_s_nxt     = shamt;
          w_k_nxt     = 3'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_w_nxt = w_stage;
        w_k_nxt = r_k + 3'd1;
        if (r_k == 3'd4) begin
          w_out_nxt   = w_stage;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_k_nxt     = 3'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_w     <= 32'h0000_0000;
      r_s     <= 5'd0;
      r_k     <= 3'd0;
      out     <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_s     <= w_s_nxt;
      r_k     <= w_k_nxt;
      out     <= w_out_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sll_iter.sv
// ============================================================================
// Module   : tb_sll_iter
// Brief    : Self-checking bench for sll_iter against an arithmetic model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sll_iter;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  sll_iter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .in      (in),
    .shamt   (shamt),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [31:0] model(input logic [31:0] a, input int sh);
    return a << sh;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for its done pulse
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh,
                        output logic [31:0] res, output int edges);
    @(negedge clock);
    start = 1'b1; in = a; shamt = sh;
    @(negedge clock);
    start = 1'b0; in = $urandom; shamt = 5'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    edges = 0;
    while (!done && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    res = out;
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int          edges;
    int          dcount;
    logic [31:0] ba[4];
    logic [4:0]  bs[4];
    logic [31:0] last;

    tbl[0] = '{32'h1234_5678, 5'd16, 32'h5678_0000};
    tbl[1] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[2] = '{32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    tbl[3] = '{32'h0000_000F, 5'd29, 32'hE000_0000};

    reset_n = 1'b0; start = 1'b0; in = '0; shamt = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_out",  out, 32'h0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].a, tbl[i].sh, res, edges);
      check("tbl_out", res, tbl[i].exp);
      check("tbl_latency", edges, 32'd5);
    end

    for (int sh = 0; sh < 32; sh++) begin
      logic [31:0] a;
      a = $urandom;
      run_op(a, 5'(sh), res, edges);
      check("rand_out", res, model(a, sh));
      check("rand_latency", edges, 32'd5);
    end

    // Second start during an operation must be ignored
    @(negedge clock);
    start = 1'b1; in = 32'h1; shamt = 5'd4;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1; in = 32'hABCD; shamt = 5'd8;
    @(negedge clock);
    start = 1'b0;
    edges = 0;
    while (!done && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    check("busy_start_out", out, 32'h0000_0010);
    check("busy_start_done_seen", {31'd0, done}, 32'd1);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("busy_start_no_second_done", dcount, 32'd0);

    // Start held high continuously: one result every 6 cycles
    for (int i = 0; i < 4; i++) begin
      ba[i] = (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      bs[i] = 5'($urandom);
    end
    @(negedge clock);
    start = 1'b1; in = ba[0]; shamt = bs[0];
    for (int i = 0; i < 4; i++) begin
      for (int c = 1; c <= 6; c++) begin
        @(negedge clock);
        if (c < 6) begin
          check("b2b_no_done", {31'd0, done}, 32'd0);
          in = $urandom; shamt = 5'($urandom);
        end else begin
          check("b2b_done", {31'd0, done}, 32'd1);
          check("b2b_out", out, model(ba[i], int'(bs[i])));
          if (i < 3) begin
            in = ba[i+1]; shamt = bs[i+1];
          end else begin
            start = 1'b0;
          end
        end
      end
    end
    last = model(ba[3], int'(bs[3]));

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in = $urandom; shamt = 5'($urandom);
      check("hold_out", out, last);
      check("hold_done", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset in the middle of an operation
    @(negedge clock);
    start = 1'b1; in = 32'hFFFF_0000; shamt = 5'd3;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_out",  out, 32'h0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("midreset_no_done", dcount, 32'd0);
    run_op(32'h3, 5'd1, res, edges);
    check("after_reset_out", res, 32'h0000_0006);
    check("after_reset_latency", edges, 32'd5);

    // Reset coinciding with the done cycle
    @(negedge clock);
    start = 1'b1; in = 32'h1; shamt = 5'd1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("pre_reset_done", {31'd0, done}, 32'd1);
    check("pre_reset_out", out, 32'h2);
    reset_n = 1'b0;
    #1;
    check("done_reset_out",  out, 32'h0);
    check("done_reset_done", {31'd0, done}, 32'd0);
    check("done_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sll_iter.md
# sll_iter

Multi-cycle 32-bit shift-left-logical unit for the processor ALU path, the left-direction counterpart to the fixed-distance arithmetic right shifters. It accepts an operand and a 5-bit shift amount under a start/busy/done handshake. It applies one binary-weighted shift stage per clock (16, 8, 4, 2, 1), so one 32-bit stage mux replaces a full 5-level barrel shifter. Results are registered and held until the next accepted operation.

## Interface
Parameters:
- none; width fixed at 32, shift amount fixed at 5 bits

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only while busy = 0
- in  input  32  operand, captured on the accepting edge
- shamt  input  5  shift distance 0..31, captured on the accepting edge
- out  output  32  registered result; holds last completed value
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse: out valid and newly updated

## Operation
- States: IDLE, SHIFT.
- Internal registers: 32-bit working value w, 5-bit captured amount s, 3-bit stage index k.
- IDLE:
  - If start = 1 at an edge, capture w = in, s = shamt, k = 0, busy = 1, then go to SHIFT.
  - Otherwise hold all registers.
- SHIFT:
  - Each edge applies stage k: k = 0 tests s[4] (shift 16), k = 1 tests s[3] (8), k = 2 tests s[2] (4), k = 3 tests s[1] (2), k = 4 tests s[0] (1).
  - If the tested bit is 1, w = w << distance with zero fill. Bits shifted past bit 31 are discarded. No sign handling.
  - If the tested bit is 0, w is unchanged.
- On the k = 4 edge:
  - out = final shifted value
  - done = 1
  - busy = 0
  - go to IDLE
- Fixed latency: every shamt takes all 5 stages, including shamt = 0. No early exit.
- start while busy = 1 is ignored. It is not queued, and in/shamt are not re-sampled.
- in and shamt may change freely after the accepting edge without affecting the result.
- out changes only on the final SHIFT edge or on reset.

## Timing
- Reset (reset_n low, asynchronous, any time):
  - out = 0x00000000, busy = 0, done = 0, state = IDLE, w = 0, s = 0, k = 0
  - An operation in flight is aborted and no done is produced.
- Release of reset_n takes effect synchronously: the first edge with reset_n high may accept start.
- Edge E0 (start = 1, busy = 0): capture; busy = 1 from after E0.
- Edges E1..E5 apply stages 16, 8, 4, 2, 1.
- After E5: out = result, done = 1 for exactly one cycle, busy = 0.
- Latency: start edge to done high is 5 edges.
- Back-to-back: start may be high in the cycle done is high. It is accepted at E6, giving one operation per 6 cycles.
- done is never high in two consecutive cycles.
- Reset asserted in the same cycle as done: reset wins; out = 0, done = 0.

## Test plan
- Reset then idle: reset_n low, then high; hold start = 0 for 10 cycles -> out = 0x00000000, busy = 0, done = 0 throughout.
- Basic shift: in = 0x12345678, shamt = 16, start 1 cycle -> busy high for 5 cycles, done pulses once, out = 0x56780000. in = 0x00000001, shamt = 31 -> out = 0x80000000.
- Zero and all-stage amounts:
  - in = 0xFFFFFFFF, shamt = 0 -> done still 5 edges after start, out = 0xFFFFFFFF.
  - in = 0x0000000F, shamt = 29 -> out = 0xE0000000.
  - Run shamt 0..31 on random operands and compare against a reference model.
- Start while busy: accept in = 0x1, shamt = 4. Two cycles later drive start = 1, in = 0xABCD, shamt = 8 -> single done, out = 0x00000010, no second done.
- Back-to-back and hold:
  - Hold start = 1 continuously with alternating operands -> done every 6 cycles, each out correct.
  - Between operations, vary in/shamt with start = 0 -> out unchanged.
- Reset mid-operation:
  - Accept in = 0xFFFF0000, shamt = 3; assert reset_n low 2 edges later -> out = 0, busy = 0 immediately, no done.
  - After release, a new operation in = 0x3, shamt = 1 -> out = 0x00000006.
